// File: rtl/dmem_access_stage.sv
// Memory-access stage of the rv32i pipeline: word loads/stores over a req/ack bus,
// front-of-pipe stall while the bus is busy, and the MEM/WB pipeline register.
module dmem_access_stage #(
  parameter int DPW     = 32,
  parameter int ADW     = 5,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           regwriteM,
  input  logic           resultsrcM,
  input  logic           memwriteM,
  input  logic [DPW-1:0] aluresultM,
  input  logic [DPW-1:0] Rd2M,
  input  logic [ADW-1:0] RdM,
  output logic           dmem_req_o,
  output logic           dmem_we_o,
  output logic [DPW-1:0] dmem_addr_o,
  output logic [DPW-1:0] dmem_wdata_o,
  output logic [3:0]     dmem_be_o,
  input  logic           dmem_ack_i,
  input  logic [DPW-1:0] dmem_rdata_i,
  output logic           stallM_o,
  output logic           regwriteW,
  output logic [ADW-1:0] RdW,
  output logic [DPW-1:0] resultW,
  output logic           bus_err_o
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          memop, misal, timeout;
  logic          req, err, stall;

  assign memop   = resultsrcM | memwriteM;
  assign misal   = memop & (aluresultM[1:0] != 2'b00);
  assign timeout = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (memop && !misal && !dmem_ack_i) begin
          state_d = WAIT;
          cnt_d   = CW'(1);
        end
      end
      WAIT: begin
        if (dmem_ack_i || timeout) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Bus outputs are gated by arst_n so an in-flight request drops the moment
  // reset asserts, not at the next edge; ack checked before timeout so it wins.
  always_comb begin
    req   = 1'b0;
    err   = 1'b0;
    stall = 1'b0;
    if (arst_n) begin
      case (state_q)
        IDLE: begin
          if (memop) begin
            if (misal) begin
              err = 1'b1;
            end else begin
              req   = 1'b1;
              stall = !dmem_ack_i;
            end
          end
        end
        WAIT: begin
          if (dmem_ack_i) begin
            req = 1'b1;
          end else if (timeout) begin
            err = 1'b1;
          end else begin
            req   = 1'b1;
            stall = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_req_o   = req;
  assign dmem_we_o    = req & memwriteM;
  assign dmem_addr_o  = aluresultM;
  assign dmem_wdata_o = Rd2M;
  assign dmem_be_o    = req ? 4'hF : 4'h0;
  assign stallM_o     = stall;
  assign bus_err_o    = err;

  // Stall cycles retire a bubble so each instruction writes back exactly once.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      regwriteW <= 1'b0;
      RdW       <= '0;
      resultW   <= '0;
    end else if (stall) begin
      regwriteW <= 1'b0;
    end else begin
      regwriteW <= regwriteM & !err;
      RdW       <= RdM;
      resultW   <= resultsrcM ? dmem_rdata_i : aluresultM;
    end
  end

endmodule

// File: tb/tb_dmem_access_stage.sv
// Directed bench for dmem_access_stage: inputs driven on the falling edge,
// outputs sampled 1 time unit later, expected values hand-computed.
module tb_dmem_access_stage;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        regwriteM, resultsrcM, memwriteM;
  logic [31:0] aluresultM, Rd2M;
  logic [4:0]  RdM;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        stallM_o, regwriteW, bus_err_o;
  logic [4:0]  RdW;
  logic [31:0] resultW;

  int checks   = 0;
  int failures = 0;
  int stalls;
  int writes;

  always #5 clk = ~clk;

  dmem_access_stage #(.DPW(32), .ADW(5), .TIMEOUT(4)) dut (
    .clk(clk), .arst_n(arst_n),
    .regwriteM(regwriteM), .resultsrcM(resultsrcM), .memwriteM(memwriteM),
    .aluresultM(aluresultM), .Rd2M(Rd2M), .RdM(RdM),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .stallM_o(stallM_o), .regwriteW(regwriteW), .RdW(RdW), .resultW(resultW),
    .bus_err_o(bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic rs, input logic mw,
                       input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] rd);
    regwriteM  = rw;
    resultsrcM = rs;
    memwriteM  = mw;
    aluresultM = alu;
    Rd2M       = rd2;
    RdM        = rd;
  endtask

  task automatic bus(input logic ack, input logic [31:0] rdata);
    dmem_ack_i   = ack;
    dmem_rdata_i = rdata;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    // Reset with a valid load on the inputs: bus must stay quiet.
    arst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd5);
    bus(1'b0, 32'h0);
    #1;
    chk("rst_req", dmem_req_o, 0);
    chk("rst_stall", stallM_o, 0);
    chk("rst_be", dmem_be_o, 0);
    chk("rst_we", dmem_we_o, 0);
    chk("rst_err", bus_err_o, 0);
    chk("rst_regwriteW", regwriteW, 0);
    chk("rst_RdW", RdW, 0);
    chk("rst_resultW", resultW, 0);
    @(negedge clk); nop();
    @(negedge clk); arst_n = 1'b1;

    // 1: lw x5,0x100 with same-cycle ack
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd5); bus(1'b1, 32'hDEADBEEF); #1;
    chk("t1_req", dmem_req_o, 1);
    chk("t1_we", dmem_we_o, 0);
    chk("t1_be", dmem_be_o, 4'hF);
    chk("t1_addr", dmem_addr_o, 32'h100);
    chk("t1_stall", stallM_o, 0);
    @(negedge clk); nop(); bus(1'b0, 32'h0); #1;
    chk("t1_regwriteW", regwriteW, 1);
    chk("t1_RdW", RdW, 5);
    chk("t1_resultW", resultW, 32'hDEADBEEF);
    chk("t1_req_after", dmem_req_o, 0);

    // 2: sw 0x1234 -> 0x40, ack on fourth request cycle
    stalls = 0;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h1234, 5'd0); bus(1'b0, 32'h0); #1;
    chk("t2_req", dmem_req_o, 1);
    chk("t2_we", dmem_we_o, 1);
    chk("t2_be", dmem_be_o, 4'hF);
    chk("t2_addr", dmem_addr_o, 32'h40);
    chk("t2_wdata", dmem_wdata_o, 32'h1234);
    stalls += int'(stallM_o);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("t2_wait_req", dmem_req_o, 1);
      chk("t2_wait_wdata", dmem_wdata_o, 32'h1234);
      chk("t2_no_wb", regwriteW, 0);
      stalls += int'(stallM_o);
    end
    @(negedge clk); bus(1'b1, 32'h0); #1;
    chk("t2_ack_stall", stallM_o, 0);
    chk("t2_ack_we", dmem_we_o, 1);
    chk("t2_ack_err", bus_err_o, 0);
    chk("t2_stall_cycles", stalls, 3);
    @(negedge clk); nop(); bus(1'b0, 32'h0); #1;
    chk("t2_regwriteW", regwriteW, 0);
    chk("t2_idle_req", dmem_req_o, 0);

    // 3: misaligned lw at 0x102
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd6); #1;
    chk("t3_req", dmem_req_o, 0);
    chk("t3_be", dmem_be_o, 0);
    chk("t3_err", bus_err_o, 1);
    chk("t3_stall", stallM_o, 0);
    @(negedge clk); nop(); #1;
    chk("t3_err_pulse", bus_err_o, 0);
    chk("t3_regwriteW", regwriteW, 0);

    // 4a: lw never acked, TIMEOUT=4
    stalls = 0;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd7); bus(1'b0, 32'h0); #1;
    stalls += int'(stallM_o);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t4_wait_err", bus_err_o, 0);
      stalls += int'(stallM_o);
    end
    @(negedge clk); #1;
    chk("t4_to_err", bus_err_o, 1);
    chk("t4_to_req", dmem_req_o, 0);
    chk("t4_to_stall", stallM_o, 0);
    chk("t4_stall_cycles", stalls, 4);
    @(negedge clk); nop(); #1;
    chk("t4_regwriteW", regwriteW, 0);
    chk("t4_err_pulse", bus_err_o, 0);

    // 4b: ack arrives in the timeout cycle -> normal completion
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h204, 32'h0, 5'd8); bus(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    @(negedge clk); bus(1'b1, 32'hCAFEF00D); #1;
    chk("t4b_req", dmem_req_o, 1);
    chk("t4b_err", bus_err_o, 0);
    chk("t4b_stall", stallM_o, 0);
    @(negedge clk); nop(); bus(1'b0, 32'h0); #1;
    chk("t4b_regwriteW", regwriteW, 1);
    chk("t4b_RdW", RdW, 8);
    chk("t4b_resultW", resultW, 32'hCAFEF00D);

    // 5: lw x9 with one wait cycle, then add x3 = 0x55
    writes = 0;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd9); bus(1'b0, 32'h0); #1;
    chk("t5_stall0", stallM_o, 1);
    if (regwriteW && RdW == 5'd9) writes++;
    @(negedge clk); bus(1'b1, 32'h11112222); #1;
    chk("t5_stall1", stallM_o, 0);
    if (regwriteW && RdW == 5'd9) writes++;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 5'd3); bus(1'b0, 32'h0); #1;
    chk("t5_add_req", dmem_req_o, 0);
    chk("t5_add_stall", stallM_o, 0);
    chk("t5_lw_RdW", RdW, 9);
    chk("t5_lw_resultW", resultW, 32'h11112222);
    if (regwriteW && RdW == 5'd9) writes++;
    @(negedge clk); nop(); bus(1'b1, 32'hFFFFFFFF); #1;
    chk("t5_add_regwriteW", regwriteW, 1);
    chk("t5_add_RdW", RdW, 3);
    chk("t5_add_resultW", resultW, 32'h55);
    chk("t5_stray_ack_req", dmem_req_o, 0);
    chk("t5_stray_ack_stall", stallM_o, 0);
    if (regwriteW && RdW == 5'd9) writes++;
    chk("t5_lw_writes", writes, 1);
    @(negedge clk); bus(1'b0, 32'h0); #1;
    chk("t5_nop_regwriteW", regwriteW, 0);

    // 6: reset during WAIT
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 5'd10); bus(1'b0, 32'h0);
    @(negedge clk); #1;
    chk("t6_wait_stall", stallM_o, 1);
    #1 arst_n = 1'b0;
    #1;
    chk("t6_rst_req", dmem_req_o, 0);
    chk("t6_rst_stall", stallM_o, 0);
    chk("t6_rst_be", dmem_be_o, 0);
    chk("t6_rst_regwriteW", regwriteW, 0);
    chk("t6_rst_RdW", RdW, 0);
    chk("t6_rst_resultW", resultW, 0);
    @(negedge clk); nop();
    // Misaligned access only raises err from IDLE, so it proves the FSM reset.
    @(negedge clk); arst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h401, 32'h0, 5'd12); #1;
    chk("t6_idle_err", bus_err_o, 1);
    chk("t6_idle_req", dmem_req_o, 0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h404, 32'h0, 5'd11); bus(1'b1, 32'h0BADF00D); #1;
    chk("t6_new_req", dmem_req_o, 1);
    chk("t6_new_stall", stallM_o, 0);
    chk("t6_bubble", regwriteW, 0);
    @(negedge clk); nop(); bus(1'b0, 32'h0); #1;
    chk("t6_new_regwriteW", regwriteW, 1);
    chk("t6_new_RdW", RdW, 11);
    chk("t6_new_resultW", resultW, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
